// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolver: control-kind encodings,
// FSM state encoding and a helper that classifies taken commands.
package branch_pkg;

    // Control kinds as decoded upstream and as issued to the PC controller
    localparam logic [2:0] KIND_SEQ = 3'b011;
    localparam logic [2:0] KIND_JMP = 3'b100;
    localparam logic [2:0] KIND_JR  = 3'b101;
    localparam logic [2:0] KIND_BEQ = 3'b110;
    localparam logic [2:0] KIND_BNE = 3'b111;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_EVAL  = 2'd1;
    localparam state_t ST_ISSUE = 2'd2;
    localparam state_t ST_FLUSH = 2'd3;

    // A command redirects fetch when it is an unconditional jump or a
    // conditional branch whose condition resolved true.
    function automatic logic is_taken(input logic [2:0] op, input logic cond);
        logic uncond;
        logic branch;
        uncond = (op == KIND_JMP) || (op == KIND_JR);
        branch = (op == KIND_BEQ) || (op == KIND_BNE);
        return uncond || (branch && cond);
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Bundle of the instruction-in handshake, the command-out handshake to the
// PC controller, and the flush/statistics outputs of the branch resolver.
// The master modport is the resolver itself; slave is its environment.
interface branch_resolver_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_kind;
    logic [31:0]      in_rs;
    logic [31:0]      in_rt;
    logic [31:0]      in_imm;

    logic [2:0]       opcode;
    logic             condition_bit;
    logic [31:0]      addr;
    logic [31:0]      jreg;
    logic             cmd_valid;
    logic             cmd_ready;

    logic             flush;
    logic [CNT_W-1:0] taken_count;

    modport master (
        input  in_valid, in_kind, in_rs, in_rt, in_imm, cmd_ready,
        output in_ready, opcode, condition_bit, addr, jreg, cmd_valid,
        output flush, taken_count
    );

    modport slave (
        output in_valid, in_kind, in_rs, in_rt, in_imm, cmd_ready,
        input  in_ready, opcode, condition_bit, addr, jreg, cmd_valid,
        input  flush, taken_count
    );

endinterface

// File: rtl/branch_compare.sv
// Full-width operand comparator producing the branch condition for beq/bne.
// Purely combinational; non-branch kinds yield a zero condition.
module branch_compare
    import branch_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  kind,
    output logic        cond
);

    logic eq;

    assign eq = (a == b);

    // Select equal / not-equal sense from the branch kind
    always_comb begin
        cond = 1'b0;
        if (kind == KIND_BEQ) begin
            cond = eq;
        end else if (kind == KIND_BNE) begin
            cond = ~eq;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: accepts one decoded control instruction at a time,
// evaluates it, issues a command to the PC controller with a valid/ready
// handshake, and holds a fetch flush for FLUSH_CYCLES after taken commands.
// Counts taken commands with a saturating counter.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
)(
    input  logic               clk,
    input  logic               rst_n,
    branch_resolver_if.master  bus
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    // Saturating increment: the counter sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t           state_q;
    state_t           state_nxt;
    logic [3:0]       flush_cnt_q;
    logic [CNT_W-1:0] taken_cnt_q;

    // Captured instruction (data only, no reset needed)
    logic [2:0]       kind_p0;
    logic [31:0]      rs_p0;
    logic [31:0]      rt_p0;
    logic [31:0]      imm_p0;

    // Registered command fields presented in ISSUE
    logic [2:0]       opcode_p1;
    logic             cond_p1;
    logic [31:0]      addr_p1;
    logic [31:0]      jreg_p1;

    // Combinational decode of the captured instruction
    logic [2:0]       nxt_opcode;
    logic             nxt_cond;
    logic [31:0]      nxt_addr;
    logic [31:0]      nxt_jreg;
    logic             cmp_cond;

    logic             accept;
    logic             issue_hs;
    logic             issue_taken;

    assign accept      = bus.in_valid && (state_q == ST_IDLE);
    assign issue_hs    = (state_q == ST_ISSUE) && bus.cmd_ready;
    assign issue_taken = issue_hs && is_taken(opcode_p1, cond_p1);

    branch_compare u_compare (
        .a    (rs_p0),
        .b    (rt_p0),
        .kind (kind_p0),
        .cond (cmp_cond)
    );

    // ---- stage p0: capture the accepted instruction ----
    // Latch operands only on a handshake so they stay put through EVAL
    always_ff @(posedge clk) begin
        if (accept) begin
            kind_p0 <= bus.in_kind;
            rs_p0   <= bus.in_rs;
            rt_p0   <= bus.in_rt;
            imm_p0  <= bus.in_imm;
        end
    end

    // Map the captured kind onto command fields; illegal kinds become sequential
    always_comb begin
        nxt_opcode = KIND_SEQ;
        nxt_cond   = 1'b0;
        nxt_addr   = '0;
        nxt_jreg   = '0;
        case (kind_p0)
            KIND_JMP: begin
                nxt_opcode = KIND_JMP;
                nxt_cond   = 1'b1;
                nxt_addr   = {16'b0, imm_p0[15:0]};
            end
            KIND_JR: begin
                nxt_opcode = KIND_JR;
                nxt_cond   = 1'b1;
                nxt_jreg   = rs_p0;
            end
            KIND_BEQ, KIND_BNE: begin
                nxt_opcode = kind_p0;
                nxt_cond   = cmp_cond;
                nxt_addr   = imm_p0;
            end
            default: begin
                nxt_opcode = KIND_SEQ;
            end
        endcase
    end

    // ---- stage p1: command registers, loaded in EVAL and held through ISSUE ----
    // Reset clears the visible command fields at once, even mid-transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_p1 <= 3'b000;
            cond_p1   <= 1'b0;
            addr_p1   <= '0;
            jreg_p1   <= '0;
        end else if (state_q == ST_EVAL) begin
            opcode_p1 <= nxt_opcode;
            cond_p1   <= nxt_cond;
            addr_p1   <= nxt_addr;
            jreg_p1   <= nxt_jreg;
        end
    end

    // Next-state logic for IDLE -> EVAL -> ISSUE -> (FLUSH) -> IDLE
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (bus.cmd_ready) state_nxt = issue_taken ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                if (flush_cnt_q <= 4'd1) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Flush down-counter: loaded on a taken handshake, counts the FLUSH cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= 4'd0;
        end else if (issue_taken) begin
            flush_cnt_q <= FLUSH_LOAD;
        end else if ((state_q == ST_FLUSH) && (flush_cnt_q != 4'd0)) begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
        end
    end

    // Taken-command statistics, bumped in the handshake cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q <= '0;
        end else if (issue_taken) begin
            taken_cnt_q <= sat_inc(taken_cnt_q);
        end
    end

    assign bus.in_ready      = (state_q == ST_IDLE);
    assign bus.cmd_valid     = (state_q == ST_ISSUE);
    assign bus.flush         = (state_q == ST_FLUSH);
    assign bus.opcode        = opcode_p1;
    assign bus.condition_bit = cond_p1;
    assign bus.addr          = addr_p1;
    assign bus.jreg          = jreg_p1;
    assign bus.taken_count   = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed, self-checking bench for branch_resolver. Expected commands are
// produced by a small reference model and queued when an instruction is
// driven; they are popped and compared when the command is issued.
module tb_branch_resolver;

    localparam int FLUSH_CYCLES = 2;

    typedef struct packed {
        logic [2:0]  op;
        logic        cond;
        logic [31:0] addr;
        logic [31:0] jreg;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    branch_resolver_if #(.CNT_W(16)) bus ();
    branch_resolver_if #(.CNT_W(2))  bus2 ();

    branch_resolver #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    branch_resolver #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of the command fields for each control kind
    function automatic exp_t model(input logic [2:0] k, input logic [31:0] rs,
                                   input logic [31:0] rt, input logic [31:0] imm);
        exp_t e;
        e.op   = 3'b011;
        e.cond = 1'b0;
        e.addr = 32'd0;
        e.jreg = 32'd0;
        case (k)
            3'b100: begin e.op = k; e.cond = 1'b1; e.addr = imm & 32'h0000_FFFF; end
            3'b101: begin e.op = k; e.cond = 1'b1; e.jreg = rs; end
            3'b110: begin e.op = k; e.cond = (rs == rt); e.addr = imm; end
            3'b111: begin e.op = k; e.cond = (rs != rt); e.addr = imm; end
            default: ;
        endcase
        return e;
    endfunction

    // Present one instruction (called at a negedge); checks the T+2 latency
    task automatic send(input logic [2:0] k, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] imm);
        int n;
        n = 0;
        sb.push_back(model(k, rs, rt, imm));
        bus.in_valid = 1'b1;
        bus.in_kind  = k;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_imm   = imm;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("eval_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check("eval_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        check("issue_cmd_valid_t2", {31'd0, bus.cmd_valid}, 32'd1);
    endtask

    // Hold cmd_ready low for 'hold' cycles, then handshake and follow the flush
    task automatic collect(input string tag, input int hold, input bit rst_in_flush);
        exp_t e;
        bit   taken;
        check({tag, "_sb_nonempty"}, {31'd0, sb.size() > 0}, 32'd1);
        e = sb.pop_front();
        for (int i = 0; i <= hold; i++) begin
            check({tag, "_cmd_valid"}, {31'd0, bus.cmd_valid}, 32'd1);
            check({tag, "_opcode"}, {29'd0, bus.opcode}, {29'd0, e.op});
            check({tag, "_cond"}, {31'd0, bus.condition_bit}, {31'd0, e.cond});
            check({tag, "_addr"}, bus.addr, e.addr);
            check({tag, "_jreg"}, bus.jreg, e.jreg);
            if (i < hold) @(negedge clk);
        end
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        taken = (e.op == 3'b100) || (e.op == 3'b101) || (e.op[2:1] == 2'b11 && e.cond);
        if (taken && exp_cnt < 65535) exp_cnt++;
        check({tag, "_taken_count"}, {16'd0, bus.taken_count}, 32'(exp_cnt));
        if (taken) begin
            for (int i = 0; i < FLUSH_CYCLES; i++) begin
                check({tag, "_flush_hi"}, {31'd0, bus.flush}, 32'd1);
                check({tag, "_flush_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
                if (rst_in_flush) begin
                    #2 rst_n = 1'b0;
                    #1;
                    exp_cnt = 0;
                    check("rst_flush", {31'd0, bus.flush}, 32'd0);
                    check("rst_taken_count", {16'd0, bus.taken_count}, 32'd0);
                    check("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
                    check("rst_opcode", {29'd0, bus.opcode}, 32'd0);
                    check("rst_cond", {31'd0, bus.condition_bit}, 32'd0);
                    check("rst_addr", bus.addr, 32'd0);
                    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
                    @(negedge clk);
                    rst_n = 1'b1;
                    break;
                end
                @(negedge clk);
            end
        end
        check({tag, "_flush_lo"}, {31'd0, bus.flush}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int w;
        bus.in_valid  = 1'b0;
        bus.in_kind   = 3'b000;
        bus.in_rs     = 32'd0;
        bus.in_rt     = 32'd0;
        bus.in_imm    = 32'd0;
        bus.cmd_ready = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_kind   = 3'b000;
        bus2.in_rs     = 32'd0;
        bus2.in_rt     = 32'd0;
        bus2.in_imm    = 32'd0;
        bus2.cmd_ready = 1'b0;

        #1;
        check("reset_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check("reset_flush", {31'd0, bus.flush}, 32'd0);
        check("reset_opcode", {29'd0, bus.opcode}, 32'd0);
        check("reset_jreg", bus.jreg, 32'd0);
        check("reset_taken_count", {16'd0, bus.taken_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

        send(3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0003);
        collect("beq_eq", 0, 1'b0);
        send(3'b111, 32'h1234_5678, 32'h1234_5678, 32'h0000_0010);
        collect("bne_eq", 0, 1'b0);
        send(3'b101, 32'h0000_0400, 32'h0000_0777, 32'h0000_0099);
        collect("jr_hold", 3, 1'b0);
        send(3'b100, 32'h0000_1111, 32'h0000_2222, 32'hFFFF_ABCD);
        collect("jmp", 0, 1'b0);
        send(3'b010, 32'h0000_AAAA, 32'h0000_BBBB, 32'h0000_CCCC);
        collect("illegal_010", 0, 1'b0);
        send(3'b011, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0042);
        collect("seq", 1, 1'b0);
        send(3'b110, 32'h8000_0005, 32'h0000_0005, 32'hFFFF_FFF0);
        collect("beq_msb", 0, 1'b0);
        send(3'b111, 32'h8000_0005, 32'h0000_0005, 32'h0000_0020);
        collect("bne_ne", 2, 1'b0);

        // cmd_ready asserted while idle must not complete anything
        bus.cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready_taken", {16'd0, bus.taken_count}, 32'(exp_cnt));
        check("idle_ready_flush", {31'd0, bus.flush}, 32'd0);
        check("idle_ready_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.cmd_ready = 1'b0;

        send(3'b110, 32'h0000_0009, 32'h0000_0009, 32'h0000_0007);
        collect("beq_rst", 0, 1'b1);
        send(3'b111, 32'h0000_0001, 32'h0000_0002, 32'h0000_0004);
        collect("after_rst", 0, 1'b0);

        // Narrow counter instance: five taken jumps saturate at 3
        bus2.cmd_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            bus2.in_valid = 1'b1;
            bus2.in_kind  = 3'b100;
            bus2.in_imm   = 32'(j);
            w = 0;
            while (bus2.in_ready !== 1'b1 && w < 50) begin
                @(negedge clk);
                w++;
            end
            @(negedge clk);
            bus2.in_valid = 1'b0;
            w = 0;
            while (bus2.in_ready !== 1'b1 && w < 50) begin
                @(negedge clk);
                w++;
            end
            check("sat_wait_idle", {31'd0, w < 50}, 32'd1);
            check("sat_taken_count", {30'd0, bus2.taken_count}, (j + 1 > 3) ? 32'd3 : 32'(j + 1));
        end
        bus2.cmd_ready = 1'b0;

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, SHALL set the number of cycles flush is held after a taken command (legal 1..15).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of taken_count.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark a decoded control instruction present.
REQ-006 in_ready  output  1  SHALL indicate the block accepts an instruction this cycle.
REQ-007 in_kind  input  3  SHALL carry the control kind: 011 sequential, 100 jump, 101 jump-register, 110 beq, 111 bne.
REQ-008 in_rs, in_rt  input  32 each  SHALL carry the source operand values.
REQ-009 in_imm  input  32  SHALL carry the sign-extended immediate, a word offset.
REQ-010 opcode  output  3  SHALL carry the command kind to the PC controller.
REQ-011 condition_bit  output  1  SHALL carry the resolved branch condition.
REQ-012 addr  output  32  SHALL carry the target field.
REQ-013 jreg  output  32  SHALL carry the register jump target.
REQ-014 cmd_valid  input-side handshake: cmd_valid output 1 and cmd_ready input 1 SHALL form the command handshake to the PC controller.
REQ-015 flush  output  1  SHALL request a fetch-pipeline flush.
REQ-016 taken_count  output  CNT_W  SHALL count taken commands.

Function
REQ-017 FSM states SHALL be IDLE, EVAL, ISSUE, and FLUSH; in_ready SHALL be 1 only in IDLE.
REQ-018 IDLE SHALL capture in_kind, in_rs, in_rt, and in_imm when in_valid and in_ready are both 1, and SHALL then go to EVAL.
REQ-019 EVAL SHALL register the outputs in one cycle and go to ISSUE; cmd_valid SHALL rise two cycles after acceptance.
REQ-020 Outputs for 011: condition_bit=0, addr=0, jreg=0.
REQ-021 Outputs for 100: addr={16'b0, imm[15:0]}, condition_bit=1.
REQ-022 Outputs for 101: jreg=rs, condition_bit=1, addr=0.
REQ-023 Outputs for 110: condition_bit=(rs==rt), addr=imm, full 32-bit compare.
REQ-024 Outputs for 111: condition_bit=(rs!=rt), addr=imm, full 32-bit compare.
REQ-025 An in_kind of 000, 001, or 010 SHALL be issued as opcode 011 with all other fields 0.
REQ-026 In ISSUE, cmd_valid SHALL be 1, and opcode, condition_bit, addr, and jreg SHALL stay stable until cmd_ready=1.
REQ-027 On an ISSUE handshake of a taken command (100, 101, or a branch with condition_bit=1), the block SHALL go to FLUSH; otherwise it SHALL go to IDLE.
REQ-028 A taken command SHALL increment taken_count in the handshake cycle, saturating at all-ones with no wrap.
REQ-029 FLUSH SHALL hold flush=1 for exactly FLUSH_CYCLES cycles using a down-counter, then return to IDLE; flush SHALL be 0 in all other states.
REQ-030 in_valid while in_ready=0 SHALL be ignored; the upstream holds the instruction.
REQ-031 cmd_ready=1 outside ISSUE SHALL have no effect.

Reset
REQ-032 rst_n low SHALL immediately force all of the following, at any state including mid-ISSUE or mid-FLUSH: state=IDLE; cmd_valid=0, flush=0, opcode=000, condition_bit=0, addr=0, jreg=0, taken_count=0; flush counter cleared.
REQ-033 After rst_n rises, in_ready SHALL be 1 at the first clock edge.

Structure
REQ-034 Shared package branch_pkg SHALL hold the kind constants (011, 100, 101, 110, 111) and the FSM state typedef.
REQ-035 The equality comparator SHALL be sub-module branch_compare (32-bit a, b, and kind in; cond out, combinational).

Verification
REQ-036 beq with rs=rt=0x0000_0005 and imm=0x0000_0003 -> cmd_valid at T+2; opcode=110, condition_bit=1, addr=3; flush high 2 cycles; taken_count=1.
REQ-037 bne with rs=rt=0x1234_5678 -> condition_bit=0; no flush; in_ready=1 the cycle after the handshake.
REQ-038 jr with rs=0x0000_0400 and cmd_ready held 0 for 3 cycles -> opcode=101 and jreg=0x400 stable for 4 cycles; flush starts after the handshake.
REQ-039 Jump with imm=0xFFFF_ABCD -> addr=0x0000_ABCD; kind 010 -> opcode 011 with all fields 0.
REQ-040 rst_n pulsed low during FLUSH cycle 1 -> flush=0 and taken_count=0 asynchronously; the next instruction is accepted normally.
REQ-041 With CNT_W=2, 5 taken jumps -> taken_count saturates at 3.
